// File: rtl/mdio_pkg.sv
// Shared constants, request shadow type and frame builder for the clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST         = 2'b01;
  localparam int         FRAME_BITS = 64;

  localparam logic [5:0] BIT_ST   = 6'd32;
  localparam logic [5:0] BIT_TA   = 6'd46;
  localparam logic [5:0] BIT_DATA = 6'd48;
  localparam logic [5:0] BIT_LAST = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } mdio_state_e;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // Full 64-bit frame, MSB transmitted first. Read frames carry 1s from TA onward;
  // the driver is released there so those bits never reach the pad.
  function automatic logic [FRAME_BITS-1:0] build_frame(input mdio_req_t r);
    return {{32{1'b1}}, ST, (r.write ? OP_WRITE : OP_READ), r.phy, r.regad,
            (r.write ? 2'b10 : 2'b11), (r.write ? r.wdata : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high while run is set,
// with single-cycle ticks flagging the edge on which MDC is about to toggle.
module mdio_clk_div #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int             CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap    = run && (r_cnt == LAST);
  assign rise_tick = w_wrap && !mdc;
  assign fall_tick = w_wrap && mdc;

  // Held at zero while idle so every frame starts at the top of a low phase.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      r_cnt <= '0;
      mdc   <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      mdc   <= ~mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one request at a time, serialised MSB-first on MDC/MDIO,
// read data and turnaround error returned with a one-cycle rsp_valid.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] BIT_TA_PHY = BIT_TA + 6'd1;

  mdio_state_e           r_state;
  mdio_req_t             r_req;
  logic [5:0]            r_bit;
  logic [15:0]           r_rx;
  logic                  r_ta;
  logic                  r_sync1, r_sync2;

  mdio_req_t             w_req_in;
  logic [FRAME_BITS-1:0] w_frame_in;
  logic [FRAME_BITS-1:0] w_frame;
  logic [5:0]            w_nbit;
  logic                  w_run, w_fall, w_rise;

  assign w_req_in   = {req_write, req_phy_addr, req_reg_addr, req_wdata};
  assign w_frame_in = build_frame(w_req_in);
  assign w_frame    = build_frame(r_req);
  assign w_nbit     = r_bit + 6'd1;
  assign w_run      = (r_state == S_FRAME);
  assign req_ready  = (r_state == S_IDLE);
  assign busy       = ~req_ready;

  mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .run       (w_run),
    .mdc       (mdc),
    .fall_tick (w_fall),
    .rise_tick (w_rise)
  );

  // mdio_i is asynchronous to clk; idle bus is pulled high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= mdio_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= '0;
      r_bit     <= '0;
      r_rx      <= '0;
      r_ta      <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req   <= w_req_in;
            r_bit   <= '0;
            mdio_o  <= w_frame_in[FRAME_BITS-1];
            mdio_oe <= 1'b1;
            r_state <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (w_rise) begin
            if (r_bit == BIT_TA_PHY) r_ta <= r_sync2;
            if (r_bit >= BIT_DATA)   r_rx <= {r_rx[14:0], r_sync2};
          end
          if (w_fall) begin
            if (r_bit == BIT_LAST) begin
              mdio_o    <= 1'b1;
              mdio_oe   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= r_req.write ? 16'h0000 : r_rx;
              rsp_err   <= r_req.write ? 1'b0 : r_ta;
              r_state   <= S_DONE;
            end else begin
              // 63 - n is the bitwise inverse of a 6-bit n.
              r_bit   <= w_nbit;
              mdio_o  <= w_frame[~w_nbit];
              mdio_oe <= r_req.write || (w_nbit < BIT_TA);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised bench for mdio_master: PHY responder on the pad, cycle-level behavioural
// model of the expected bus waveform and responses, and a few hand-computed anchors.
module tb_mdio_master;

  localparam int         D         = 4;
  localparam int         FRAME_CYC = 128 * D;
  localparam logic [4:0] PHY_ADDR  = 5'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy_addr = '0;
  logic [4:0]  req_reg_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;
  logic        mdio_i;
  logic        phy_en, phy_val;

  // Pad: master driver, else PHY driver, else pull-up.
  assign mdio_i = mdio_oe ? mdio_o : (phy_en ? phy_val : 1'b1);

  mdio_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (updated on every rising clk edge) ----------
  int          edge_cnt = 0;
  logic        m_on = 1'b0;
  logic        m_rst_prev = 1'b1;
  int          m_off = 0;     // 0 idle, 1..FRAME_CYC in frame, FRAME_CYC+1 response cycle
  logic        m_write = 1'b0;
  logic [4:0]  m_phy = '0, m_reg = '0;
  logic [15:0] m_wdata = '0;
  logic [63:0] m_frame = '0;
  logic [15:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic [15:0] sb_regs [32];
  int          acc_edge = 0, prev_acc_edge = 0, n_acc = 0;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
    m_rst_prev = reset;
    if (reset) begin
      m_on = 1'b1; m_off = 0; m_rdata = '0; m_err = 1'b0;
    end else if (m_off == FRAME_CYC + 1) begin
      m_off = 0;
    end else if (m_off > 0) begin
      m_off++;
      if (m_off == FRAME_CYC + 1) begin
        if (m_write) begin
          m_rdata = '0; m_err = 1'b0;
          if (m_phy == PHY_ADDR) sb_regs[m_reg] = m_wdata;
        end else if (m_phy == PHY_ADDR) begin
          m_rdata = sb_regs[m_reg]; m_err = 1'b0;
        end else begin
          m_rdata = 16'hFFFF; m_err = 1'b1;
        end
      end
    end else if (req_valid) begin
      m_write = req_write; m_phy = req_phy_addr; m_reg = req_reg_addr; m_wdata = req_wdata;
      m_frame = {32'hFFFF_FFFF, 2'b01, (req_write ? 2'b01 : 2'b10), req_phy_addr,
                 req_reg_addr, 2'b10, req_wdata};
      m_off = 1;
      prev_acc_edge = acc_edge;
      acc_edge = edge_cnt;
      n_acc++;
    end
  end

  // ---------------- compare process (falling clk edge) ----------------------------
  int   rsp_cnt = 0;
  logic prev_o = 1'b1, prev_mdc = 1'b0;

  initial forever begin
    int b, ph;
    logic e_mdc, e_oe, e_o, mask_o, e_ready, e_vld;
    @(negedge clk);
    if (m_on) begin
      e_mdc = 1'b0; e_oe = 1'b0; e_o = 1'b1; mask_o = 1'b0;
      e_ready = (m_off == 0);
      e_vld = (m_off == FRAME_CYC + 1);
      if (m_off >= 1 && m_off <= FRAME_CYC) begin
        b  = (m_off - 1) / (2 * D);
        ph = (m_off - 1) % (2 * D);
        e_mdc  = (ph >= D);
        e_oe   = m_write || (b < 46);
        e_o    = m_frame[63 - b];
        mask_o = !e_oe;
      end
      if (e_vld) mask_o = 1'b1;
      chk("cycle",
          {41'd0, req_ready, busy, mdc, mdio_oe, (mask_o ? 1'b0 : mdio_o), rsp_valid, rsp_err, rsp_rdata},
          {41'd0, e_ready, !e_ready, e_mdc, e_oe, (mask_o ? 1'b0 : e_o), e_vld, m_err, m_rdata});
      if (rsp_valid) begin
        rsp_cnt++;
        chk("rsp_latency", 64'(edge_cnt - acc_edge + 1), 64'd513);
      end
      if (!m_rst_prev && mdio_o !== prev_o)
        chk("mdio_o_on_fall", {62'd0, prev_mdc, mdc}, 64'b10);
    end
    prev_o = mdio_o;
    prev_mdc = mdc;
  end

  // ---------------- PHY responder (reacts to DUT MDC rises) -----------------------
  logic [15:0] phy_regs [32];
  logic [63:0] phy_sh = '0;
  logic [31:0] phy_last = '0;
  logic [4:0]  phy_rreg = '0;
  logic [15:0] phy_word;
  logic        phy_rd = 1'b0, phy_prev_mdc = 1'b0;
  int          phy_rises = 0;

  initial begin
    phy_en = 1'b0; phy_val = 1'b1;
    forever begin
      @(negedge clk);
      if (reset || m_off == 0) begin
        phy_rises = 0; phy_en = 1'b0; phy_rd = 1'b0;
      end else if (mdc && !phy_prev_mdc) begin
        phy_sh = {phy_sh[62:0], mdio_i};
        if (phy_rises == 45 && phy_sh[13:10] == 4'b0110 && phy_sh[9:5] == PHY_ADDR) begin
          phy_rd = 1'b1; phy_rreg = phy_sh[4:0];
        end
        if (phy_rd && phy_rises == 46) begin
          phy_en = 1'b1; phy_val = 1'b0;
        end else if (phy_rd && phy_rises >= 47 && phy_rises <= 62) begin
          phy_word = phy_regs[phy_rreg];
          phy_val = phy_word[62 - phy_rises];
        end else if (phy_rises == 63) begin
          phy_en = 1'b0;
          phy_last = phy_sh[31:0];
          if (phy_sh[31:28] == 4'b0101 && phy_sh[27:23] == PHY_ADDR && phy_sh[17:16] == 2'b10)
            phy_regs[phy_sh[22:18]] = phy_sh[15:0];
        end
        phy_rises++;
      end
      phy_prev_mdc = mdc;
    end
  end

  // ---------------- stimulus ------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(input logic w, input logic [4:0] p, input logic [4:0] r,
                        input logic [15:0] d);
    int n0;
    n0 = n_acc;
    req_valid = 1'b1; req_write = w; req_phy_addr = p; req_reg_addr = r; req_wdata = d;
    for (int i = 0; i < 2000 && n_acc == n0; i++) step();
    chk("accept", 64'(n_acc - n0), 64'd1);
    req_valid = 1'b0;
    // Scramble the request bus mid-frame; the latched copy must be used.
    req_write = 1'($urandom); req_phy_addr = 5'($urandom);
    req_reg_addr = 5'($urandom); req_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(output logic [15:0] rd, output logic er);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step();
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", {63'd0, got}, 64'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          n0, r0;
    for (int i = 0; i < 32; i++) begin
      phy_regs[i] = 16'h1000 + 16'(i * 16'h0111);
      sb_regs[i]  = phy_regs[i];
    end
    phy_regs[2] = 16'h004D;
    sb_regs[2]  = 16'h004D;

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_state", {41'd0, req_ready, busy, mdc, mdio_o, mdio_oe, rsp_valid, rsp_err, rsp_rdata},
        {41'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});

    // Write phy=1 reg=0 0x1140; last 32 bits on the wire are fixed by the frame layout.
    do_req(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp(rd, er);
    chk("t1_wire_bits", {32'd0, phy_last}, {32'd0, 32'h5082_1140});
    chk("t1_rsp", {47'd0, er, rd}, {47'd0, 1'b0, 16'h0000});

    // Read phy=1 reg=2 answered by the PHY.
    do_req(1'b0, 5'd1, 5'd2, 16'h0);
    wait_rsp(rd, er);
    chk("t2_rsp", {47'd0, er, rd}, {47'd0, 1'b0, 16'h004D});

    // Read of an absent PHY sees the pull-up.
    do_req(1'b0, 5'd7, 5'd2, 16'h0);
    wait_rsp(rd, er);
    chk("t3_rsp", {47'd0, er, rd}, {47'd0, 1'b1, 16'hFFFF});

    // Two requests with req_valid held high throughout.
    n0 = n_acc;
    req_valid = 1'b1; req_write = 1'b1; req_phy_addr = 5'd1; req_reg_addr = 5'd5;
    req_wdata = 16'hA5C3;
    for (int i = 0; i < 2000 && n_acc == n0; i++) step();
    req_reg_addr = 5'd6; req_wdata = 16'h3C5A;
    for (int i = 0; i < 2000 && n_acc == n0 + 1; i++) step();
    chk("t4_accepts", 64'(n_acc - n0), 64'd2);
    chk("t4_gap", 64'(acc_edge - prev_acc_edge), 64'd514);
    req_valid = 1'b0; req_wdata = 16'h0F0F;
    wait_rsp(rd, er);
    do_req(1'b0, 5'd1, 5'd5, 16'h0);
    wait_rsp(rd, er);
    chk("t4_rd5", {48'd0, rd}, {48'd0, 16'hA5C3});
    do_req(1'b0, 5'd1, 5'd6, 16'h0);
    wait_rsp(rd, er);
    chk("t4_rd6", {48'd0, rd}, {48'd0, 16'h3C5A});

    // Reset during bit 40 of a read.
    do_req(1'b0, 5'd1, 5'd2, 16'h0);
    for (int i = 0; i < 1000 && m_off < 40 * 2 * D + 3; i++) step();
    reset = 1'b1;
    step();
    chk("t5_abort", {44'd0, mdc, mdio_oe, req_ready, rsp_valid, rsp_rdata},
        {44'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
    reset = 1'b0;
    r0 = rsp_cnt;
    repeat (600) step();
    chk("t5_no_rsp", 64'(rsp_cnt - r0), 64'd0);

    // Randomised traffic; the compare process checks every cycle against the model.
    for (int k = 0; k < 16; k++) begin
      do_req(1'($urandom), (($urandom % 4) == 0) ? 5'($urandom) : PHY_ADDR,
             5'($urandom), 16'($urandom));
      wait_rsp(rd, er);
      repeat ($urandom % 5) step();
    end

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
